gpr_write_arbiter: RTL
======================

// Module: gpr_write_arbiter
// PURPOSE
//  - Shares the single GPR write port (RegWr/rd/datain) among N writeback requesters:
//    ALU, load unit, mult/div unit and CP0/link.
//  - Round-robin arbitration with valid/ready handshakes.
//  - Registers the winning write one cycle before it reaches the register file.
//  - Forwards the staged write to the two read ports (rs/rt), so readers never see stale data.
// PARAMETERS
//  N_REQ   4   number of writeback requesters (2..8)
//  ADDR_W  5   register index width
//  DATA_W  32  register data width
//  CNT_W   16  width of the saturating dropped-zero-write counter
// PORTS
//  clk           in   1             clock, rising edge
//  reset         in   1             asynchronous, active-high
//  arb_en        in   1             1 = arbitration enabled; 0 = no grants, pointer frozen
//  req_valid     in   N_REQ         per-requester write request
//  req_addr      in   N_REQ*ADDR_W  flattened destination index, requester i at [i*ADDR_W +: ADDR_W]
//  req_data      in   N_REQ*DATA_W  flattened write data, requester i at [i*DATA_W +: DATA_W]
//  req_ready     out  N_REQ         one-hot grant; transfer when req_valid[i] && req_ready[i]
//  gpr_wr_en     out  1             to GPR RegWr
//  gpr_wr_addr   out  ADDR_W        to GPR rd
//  gpr_wr_data   out  DATA_W        to GPR datain
//  rd_rs         in   ADDR_W        read index A, the same value driven to GPR rs
//  rd_rt         in   ADDR_W        read index B, the same value driven to GPR rt
//  gpr_busA      in   DATA_W        GPR busA
//  gpr_busB      in   DATA_W        GPR busB
//  busA_fwd      out  DATA_W        forwarded read data A
//  busB_fwd      out  DATA_W        forwarded read data B
//  zero_drop_cnt out  CNT_W         count of accepted writes to r0
// BEHAVIOUR
//  - Reset (async):
//    - gpr_wr_en=0, gpr_wr_addr=0, gpr_wr_data=0.
//    - rr_ptr=0, zero_drop_cnt=0, req_ready=0.
//    - A write staged when reset asserts is discarded.
//  - Arbitration (combinational in cycle k):
//    - grant = first i with req_valid[i], searching rr_ptr, rr_ptr+1, ... mod N_REQ.
//    - req_ready = grant when arb_en=1, else all zeros.
//    - At most one bit of req_ready is high; req_ready is never high for a non-valid requester.
//    - Requesters hold addr/data stable while valid && !ready; valid may not drop before ready.
//  - Pointer update:
//    - On a grant to i, rr_ptr <= (i+1) mod N_REQ; wrap from N_REQ-1 to 0.
//    - With no grant, rr_ptr holds.
//  - Write stage (edge k+1):
//    - gpr_wr_en <= grant_any && (addr != 0).
//    - gpr_wr_addr/gpr_wr_data <= winner's addr/data; they hold their last value when there is no grant.
//    - The GPR commits at edge k+2. Latency from handshake to register-file update is 2 edges.
//    - Sustained throughput: one write per cycle.
//  - r0 writes:
//    - The handshake completes normally and gpr_wr_en stays 0.
//    - zero_drop_cnt increments and saturates at all-ones.
//  - Forwarding (combinational):
//    - busA_fwd = (gpr_wr_en && gpr_wr_addr==rd_rs && rd_rs!=0) ? gpr_wr_data : gpr_busA.
//    - busB_fwd follows the same rule with rd_rt and gpr_busB.
//    - r0 always reads the GPR value, which is 0.
//  - Same-address writes:
//    - They serialise in grant order; the last granted value wins.
//    - Forwarding always reflects the staged (newest) write.
//  - arb_en falling mid-stream: an already-staged write still commits; no new grants are issued.
// STRUCTURE
//  - gpr_pkg holds ADDR_W, DATA_W, ZERO_REG=5'd0 and the flatten/slice index helpers.
//  - Sub-module rr_arbiter #(N) (valid, en, grant, grant_idx) holds rr_ptr and the rotate-priority search.
//  - The top level holds the write-stage registers, the r0 filter, the counter and the forward muxes.
// TESTING
//  - Reset: assert reset mid-stream with a staged write to r5
//    -> gpr_wr_en=0 immediately, rr_ptr=0, zero_drop_cnt=0, r5 is never written.
//  - Round-robin with all four valid continuously
//    -> grants in order 0,1,2,3,0 on consecutive cycles; each request is held until its own ready.
//  - Ptr wrap: rr_ptr=3, only req0 and req3 valid -> req3 granted first, then req0; rr_ptr ends at 1.
//  - r0 write: req1 writes addr 0, data 0xDEADBEEF
//    -> req_ready[1]=1, gpr_wr_en stays 0, zero_drop_cnt 0->1; saturate check from preload 0xFFFF.
//  - Forwarding: req2 writes r7=0x12345678 and rd_rs=7 in the staging cycle
//    -> busA_fwd=0x12345678; the next cycle gpr_busA supplies it.
//  - Same address: req0 writes r9=1, then req1 writes r9=2 back-to-back
//    -> final r9=2; busB_fwd with rd_rt=9 reads 1, then 2.

Source files
------------

// File: rtl/gpr_pkg.sv
// rtl/gpr_pkg.sv - shared widths, the r0 index and index helpers for the GPR write arbiter
package gpr_pkg;

    localparam int GPR_ADDR_W = 5;
    localparam int GPR_DATA_W = 32;

    // Register r0 is hard-wired to zero in the register file.
    localparam logic [GPR_ADDR_W-1:0] ZERO_REG = 5'd0;

    // Low bit of element idx inside a flattened bus of width-wide elements.
    function automatic int slice_lo(input int idx, input int width);
        return idx * width;
    endfunction

    // Index visited at step k of a rotating search that starts at base, modulo n.
    function automatic int rot_idx(input int base, input int k, input int n);
        int j;
        j = base + k;
        if (j >= n) begin
            j = j - n;
        end
        return j;
    endfunction

    // Successor of idx modulo n, wrapping from n-1 back to 0.
    function automatic int wrap_inc(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/gpr_write_arbiter_rr_arbiter.sv
// rtl/gpr_write_arbiter_rr_arbiter.sv - round-robin arbiter owning the rotating priority pointer
module rr_arbiter
    import gpr_pkg::*;
#(
    parameter int N = 4,
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N-1:0]     valid,
    input  logic             en,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] grant_idx
);

    logic [IDX_W-1:0] rr_ptr;
    logic             found;

    // Search the requesters starting at rr_ptr; the first valid one wins.
    always_comb begin
        found     = 1'b0;
        grant_idx = '0;
        for (int k = 0; k < N; k++) begin
            if (!found && valid[rot_idx(int'(rr_ptr), k, N)]) begin
                found     = 1'b1;
                grant_idx = IDX_W'(rot_idx(int'(rr_ptr), k, N));
            end
        end
    end

    // One-hot grant, suppressed entirely while arbitration is disabled.
    always_comb begin
        grant = '0;
        if (en && found) begin
            grant[grant_idx] = 1'b1;
        end
    end

    // Move priority just past the winner; with no grant the pointer holds.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr <= '0;
        end else if (en && found) begin
            rr_ptr <= IDX_W'(wrap_inc(int'(grant_idx), N));
        end
    end

endmodule

// File: rtl/gpr_write_arbiter.sv
// rtl/gpr_write_arbiter.sv - shares the GPR write port among writeback units and forwards the staged write
module gpr_write_arbiter
    import gpr_pkg::*;
#(
    parameter int N_REQ  = 4,
    parameter int ADDR_W = GPR_ADDR_W,
    parameter int DATA_W = GPR_DATA_W,
    parameter int CNT_W  = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    arb_en,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [N_REQ*ADDR_W-1:0] req_addr,
    input  logic [N_REQ*DATA_W-1:0] req_data,
    output logic [N_REQ-1:0]        req_ready,
    output logic                    gpr_wr_en,
    output logic [ADDR_W-1:0]       gpr_wr_addr,
    output logic [DATA_W-1:0]       gpr_wr_data,
    input  logic [ADDR_W-1:0]       rd_rs,
    input  logic [ADDR_W-1:0]       rd_rt,
    input  logic [DATA_W-1:0]       gpr_busA,
    input  logic [DATA_W-1:0]       gpr_busB,
    output logic [DATA_W-1:0]       busA_fwd,
    output logic [DATA_W-1:0]       busB_fwd,
    output logic [CNT_W-1:0]        zero_drop_cnt
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);

    logic [N_REQ-1:0]  grant;
    logic [IDX_W-1:0]  grant_idx;
    logic              grant_any;
    logic              arb_active;
    logic [ADDR_W-1:0] win_addr;
    logic [DATA_W-1:0] win_data;
    logic              win_is_zero;

    // No requester may see ready while reset is held, even if it is already valid.
    assign arb_active = arb_en && !reset;

    rr_arbiter #(
        .N(N_REQ)
    ) u_rr_arbiter (
        .clk       (clk),
        .reset     (reset),
        .valid     (req_valid),
        .en        (arb_active),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    assign req_ready = grant;
    assign grant_any = |grant;

    // Pick the winner's destination and data out of the flattened request buses.
    always_comb begin
        win_addr    = req_addr[slice_lo(int'(grant_idx), ADDR_W) +: ADDR_W];
        win_data    = req_data[slice_lo(int'(grant_idx), DATA_W) +: DATA_W];
        win_is_zero = (win_addr == ZERO_ADDR);
    end

    // Stage the granted write one cycle ahead of the register file; r0 writes never assert the enable.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gpr_wr_en   <= 1'b0;
            gpr_wr_addr <= '0;
            gpr_wr_data <= '0;
        end else begin
            gpr_wr_en <= grant_any && !win_is_zero;
            if (grant_any) begin
                gpr_wr_addr <= win_addr;
                gpr_wr_data <= win_data;
            end
        end
    end

    // Count accepted writes to r0, sticking at all-ones instead of wrapping.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            zero_drop_cnt <= '0;
        end else if (grant_any && win_is_zero && (zero_drop_cnt != {CNT_W{1'b1}})) begin
            zero_drop_cnt <= zero_drop_cnt + 1'b1;
        end
    end

    // Bypass the staged write to the read ports so readers never see the pre-commit value.
    always_comb begin
        busA_fwd = gpr_busA;
        busB_fwd = gpr_busB;
        if (gpr_wr_en && (gpr_wr_addr == rd_rs) && (rd_rs != ZERO_ADDR)) begin
            busA_fwd = gpr_wr_data;
        end
        if (gpr_wr_en && (gpr_wr_addr == rd_rt) && (rd_rt != ZERO_ADDR)) begin
            busB_fwd = gpr_wr_data;
        end
    end

endmodule
